// File: rtl/cordic_sincos_seq.sv
// Sequential sin/cos unit: wraps an unsigned angle mod 2*pi, folds it to the first quadrant,
// then runs an iterative CORDIC. Both results are returned through one valid/ready handshake.
module cordic_sincos_seq #(
    parameter int unsigned WII   = 4,
    parameter int unsigned WIF   = 8,
    parameter int unsigned WOI   = 2,
    parameter int unsigned WOF   = 12,
    parameter int unsigned ITERS = 14,
    parameter int unsigned GUARD = 3,
    parameter int unsigned SNAP  = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WII+WIF-1:0]   in_angle,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WOI+WOF-1:0]   out_sin,
    output logic [WOI+WOF-1:0]   out_cos
);

    localparam int unsigned WA   = WII + WIF;
    localparam int unsigned OW   = WOI + WOF;
    localparam int unsigned WFG  = WOF + GUARD;
    localparam int unsigned DW   = WFG + 3;
    localparam int unsigned IW   = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam int unsigned SH_L = (WFG >= WIF) ? (WFG - WIF) : 0;
    localparam int unsigned SH_R = (WIF > WFG) ? (WIF - WFG) : 0;

    localparam real R_PI = 3.14159265358979323846;
    localparam real R_SA = 2.0 ** WIF;
    localparam real R_SZ = 2.0 ** WFG;

    localparam logic [WA-1:0] C_PI_2  = WA'($rtoi(0.5 * R_PI * R_SA + 0.5));
    localparam logic [WA-1:0] C_PI    = WA'($rtoi(R_PI * R_SA + 0.5));
    localparam logic [WA-1:0] C_3PI_2 = WA'($rtoi(1.5 * R_PI * R_SA + 0.5));
    localparam logic [WA-1:0] C_2PI   = WA'($rtoi(2.0 * R_PI * R_SA + 0.5));

    localparam logic signed [DW-1:0] C_K    = DW'($rtoi(0.6072529350 * R_SZ + 0.5));
    localparam logic signed [DW-1:0] C_HALF = (GUARD > 0) ? DW'(1) << (GUARD - 1) : '0;
    localparam logic signed [DW-1:0] C_ONE  = DW'(1) << WOF;
    localparam logic signed [DW-1:0] C_SNAP = DW'(SNAP);
    localparam logic signed [DW-1:0] C_MAX  = (DW'(1) << (OW - 1)) - DW'(1);
    localparam logic signed [DW-1:0] C_MIN  = -C_MAX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REDUCE,
        S_ITER,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [WA-1:0]         r_a;
    logic signed [DW-1:0]  r_x;
    logic signed [DW-1:0]  r_y;
    logic signed [DW-1:0]  r_z;
    logic [IW-1:0]         r_i;
    logic                  r_sin_neg;
    logic                  r_cos_neg;
    logic                  r_out_valid;
    logic [OW-1:0]         r_sin;
    logic [OW-1:0]         r_cos;

    logic [WA-1:0]         w_fold;
    logic                  w_sin_neg;
    logic                  w_cos_neg;
    logic signed [DW-1:0]  w_z0;
    logic                  w_d;
    logic signed [DW-1:0]  w_xs;
    logic signed [DW-1:0]  w_ys;
    logic signed [DW-1:0]  w_x_nx;
    logic signed [DW-1:0]  w_y_nx;
    logic signed [DW-1:0]  w_z_nx;
    logic [OW-1:0]         w_sin_f;
    logic [OW-1:0]         w_cos_f;
    logic                  w_accept;
    logic signed [DW-1:0]  w_atan [ITERS];

    // atan(2^-i) table, fixed at elaboration
    for (genvar g = 0; g < ITERS; g++) begin : g_atan
        assign w_atan[g] = DW'($rtoi($atan(2.0 ** (-g)) * R_SZ + 0.5));
    end

    // sign, round, snap and saturate one CORDIC magnitude into the output format
    function automatic logic [OW-1:0] f_form(input logic signed [DW-1:0] mag, input logic neg);
        logic signed [DW-1:0] v;
        logic signed [DW-1:0] m;
        v = neg ? -mag : mag;
        v = (v + C_HALF) >>> GUARD;
        m = v[DW-1] ? -v : v;
        if (m <= C_SNAP) begin
            v = '0;
        end else if ((m >= C_ONE - C_SNAP) && (m <= C_ONE + C_SNAP)) begin
            v = v[DW-1] ? -C_ONE : C_ONE;
        end
        if (v > C_MAX) begin
            v = C_MAX;
        end else if (v < C_MIN) begin
            v = C_MIN;
        end
        return OW'(v);
    endfunction

    // in DONE a consumed result frees the unit in the same cycle
    assign in_ready  = rstn & ((r_state == S_IDLE) |
                               ((r_state == S_DONE) & r_out_valid & out_ready));
    assign w_accept  = in_valid & in_ready;
    assign out_valid = r_out_valid;
    assign out_sin   = r_sin;
    assign out_cos   = r_cos;

    // quadrant fold of an angle already below 2*pi; boundaries go to the higher quadrant
    always_comb begin
        w_fold    = '0;
        w_sin_neg = 1'b0;
        w_cos_neg = 1'b0;
        if (r_a < C_PI_2) begin
            w_fold = r_a;
        end else if (r_a < C_PI) begin
            w_fold    = C_PI - r_a;
            w_cos_neg = 1'b1;
        end else if (r_a < C_3PI_2) begin
            w_fold    = r_a - C_PI;
            w_sin_neg = 1'b1;
            w_cos_neg = 1'b1;
        end else begin
            w_fold    = C_2PI - r_a;
            w_sin_neg = 1'b1;
        end
    end

    assign w_z0 = (DW'(w_fold) << SH_L) >> SH_R;

    // one CORDIC micro-rotation
    always_comb begin
        w_d    = ~r_z[DW-1];
        w_xs   = r_x >>> r_i;
        w_ys   = r_y >>> r_i;
        w_x_nx = r_x;
        w_y_nx = r_y;
        w_z_nx = r_z;
        if (w_d) begin
            w_x_nx = r_x - w_ys;
            w_y_nx = r_y + w_xs;
            w_z_nx = r_z - w_atan[r_i];
        end else begin
            w_x_nx = r_x + w_ys;
            w_y_nx = r_y - w_xs;
            w_z_nx = r_z + w_atan[r_i];
        end
    end

    assign w_sin_f = f_form(r_y, r_sin_neg);
    assign w_cos_f = f_form(r_x, r_cos_neg);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_i         <= '0;
            r_sin_neg   <= 1'b0;
            r_cos_neg   <= 1'b0;
            r_out_valid <= 1'b0;
            r_sin       <= '0;
            r_cos       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= in_angle;
                        r_state <= S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    if (r_a >= C_2PI) begin
                        r_a <= r_a - C_2PI;
                    end else begin
                        r_z       <= w_z0;
                        r_x       <= C_K;
                        r_y       <= '0;
                        r_i       <= '0;
                        r_sin_neg <= w_sin_neg;
                        r_cos_neg <= w_cos_neg;
                        r_state   <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_x <= w_x_nx;
                    r_y <= w_y_nx;
                    r_z <= w_z_nx;
                    r_i <= r_i + IW'(1);
                    if (r_i == IW'(ITERS - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // first DONE cycle forms the results; afterwards hold until consumed
                    if (!r_out_valid) begin
                        r_sin       <= w_sin_f;
                        r_cos       <= w_cos_f;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_accept) begin
                            r_a     <= in_angle;
                            r_state <= S_REDUCE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
